// File: rtl/idexe_reg.sv
// ID/EXE pipeline register with load-use hazard detection and bubble insertion.
// Optional macro IDEXE_BRANCH_LU_EN adds a second bubble for ID-resolved branches that depend on a load.
module idexe_reg (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [4:0]  IFID_rs,
    input  logic [4:0]  IFID_rt,
    input  logic        use_rs_i,
    input  logic        use_rt_i,
    input  logic        is_branch_i,
    input  logic [4:0]  rd_i,
    input  logic        RFWr_i,
    input  logic        DMRd_i,
    input  logic        ALUSrc1_i,
    input  logic        ALUSrc2_i,
    input  logic [1:0]  DMWr_i,
    input  logic [1:0]  WDSel_i,
    input  logic [4:0]  ALUOp_i,
    input  logic [31:0] PC_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] rsdata_i,
    input  logic [31:0] rtdata_i,
    output logic [4:0]  IDEXE_rs,
    output logic [4:0]  IDEXE_rt,
    output logic [4:0]  IDEXE_rd,
    output logic        IDEXE_RFWr,
    output logic        IDEXE_DMRd,
    output logic [1:0]  IDEXE_DMWr,
    output logic [1:0]  IDEXE_WDSel,
    output logic [4:0]  IDEXE_ALUOp,
    output logic        IDEXE_ALUSrc1,
    output logic        IDEXE_ALUSrc2,
    output logic [31:0] IDEXE_PC,
    output logic [31:0] IDEXE_imm,
    output logic [31:0] IDEXE_rsdata,
    output logic [31:0] IDEXE_rtdata,
    output logic        IDEXE_valid,
    output logic        hazard_stall_o
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rf_wr;
        logic        dm_rd;
        logic [1:0]  dm_wr;
        logic [1:0]  wd_sel;
        logic [4:0]  alu_op;
        logic        alu_src1;
        logic        alu_src2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } fields_t;

`ifdef IDEXE_BRANCH_LU_EN
    typedef enum logic {IDLE = 1'b0, BUB2 = 1'b1} state_t;
`else
    typedef enum logic {IDLE = 1'b0} state_t;
    logic unused_is_branch;
    assign unused_is_branch = is_branch_i;
`endif

    state_t  state;
    state_t  state_after_bubble;
    fields_t q;
    fields_t d_load;
    logic    lu;

    assign d_load = '{
        valid:    1'b1,
        rs:       IFID_rs,
        rt:       IFID_rt,
        rd:       rd_i,
        rf_wr:    RFWr_i,
        dm_rd:    DMRd_i,
        dm_wr:    DMWr_i,
        wd_sel:   WDSel_i,
        alu_op:   ALUOp_i,
        alu_src1: ALUSrc1_i,
        alu_src2: ALUSrc2_i,
        pc:       PC_i,
        imm:      imm_i,
        rs_data:  rsdata_i,
        rt_data:  rtdata_i
    };

    // A load in EXE whose destination is read by the ID instruction; $0 never conflicts.
    assign lu = q.valid & q.dm_rd & (q.rd != 5'd0) &
                ((use_rs_i & (IFID_rs == q.rd)) | (use_rt_i & (IFID_rt == q.rd)));

    always_comb begin
        hazard_stall_o = 1'b0;
        case (state)
            IDLE:    hazard_stall_o = lu & ~flush_i;
`ifdef IDEXE_BRANCH_LU_EN
            BUB2:    hazard_stall_o = ~flush_i;
`endif
            default: hazard_stall_o = 1'b0;
        endcase
    end

`ifdef IDEXE_BRANCH_LU_EN
    // A branch compares in ID, so a loaded operand needs one more cycle than an ALU consumer.
    assign state_after_bubble = (state == IDLE && is_branch_i) ? BUB2 : IDLE;
`else
    assign state_after_bubble = IDLE;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q     <= '0;
            state <= IDLE;
        end else if (!stall_i) begin
            if (flush_i) begin
                q     <= '0;
                state <= IDLE;
            end else if (hazard_stall_o) begin
                q     <= '0;
                state <= state_after_bubble;
            end else begin
                q     <= d_load;
                state <= IDLE;
            end
        end
    end

    assign IDEXE_valid   = q.valid;
    assign IDEXE_rs      = q.rs;
    assign IDEXE_rt      = q.rt;
    assign IDEXE_rd      = q.rd;
    assign IDEXE_RFWr    = q.rf_wr;
    assign IDEXE_DMRd    = q.dm_rd;
    assign IDEXE_DMWr    = q.dm_wr;
    assign IDEXE_WDSel   = q.wd_sel;
    assign IDEXE_ALUOp   = q.alu_op;
    assign IDEXE_ALUSrc1 = q.alu_src1;
    assign IDEXE_ALUSrc2 = q.alu_src2;
    assign IDEXE_PC      = q.pc;
    assign IDEXE_imm     = q.imm;
    assign IDEXE_rsdata  = q.rs_data;
    assign IDEXE_rtdata  = q.rt_data;

endmodule

// File: tb/tb_idexe_reg.sv
// Directed scoreboard bench for idexe_reg; branch expectations follow IDEXE_BRANCH_LU_EN.
module tb_idexe_reg;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        rf_wr;
        logic        dm_rd;
        logic [1:0]  dm_wr;
        logic [1:0]  wd_sel;
        logic [4:0]  alu_op;
        logic        alu_src1;
        logic        alu_src2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } id_t;

    localparam int K_LOAD = 0;
    localparam int K_BUB  = 1;
    localparam int K_HOLD = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic stall_i = 1'b0, flush_i = 1'b0;
    logic use_rs_i = 1'b0, use_rt_i = 1'b0, is_branch_i = 1'b0;
    id_t  din = '0;
    id_t  dout;
    logic hazard_stall_o;

    logic [4:0]  o_rs, o_rt, o_rd, o_alu_op;
    logic        o_rf_wr, o_dm_rd, o_alu_src1, o_alu_src2, o_valid;
    logic [1:0]  o_dm_wr, o_wd_sel;
    logic [31:0] o_pc, o_imm, o_rs_data, o_rt_data;

    id_t exp_q[$];
    id_t last_exp = '0;
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    idexe_reg dut (
        .clk(clk), .rstn(rstn), .stall_i(stall_i), .flush_i(flush_i),
        .IFID_rs(din.rs), .IFID_rt(din.rt),
        .use_rs_i(use_rs_i), .use_rt_i(use_rt_i), .is_branch_i(is_branch_i),
        .rd_i(din.rd), .RFWr_i(din.rf_wr), .DMRd_i(din.dm_rd),
        .ALUSrc1_i(din.alu_src1), .ALUSrc2_i(din.alu_src2),
        .DMWr_i(din.dm_wr), .WDSel_i(din.wd_sel), .ALUOp_i(din.alu_op),
        .PC_i(din.pc), .imm_i(din.imm), .rsdata_i(din.rs_data), .rtdata_i(din.rt_data),
        .IDEXE_rs(o_rs), .IDEXE_rt(o_rt), .IDEXE_rd(o_rd),
        .IDEXE_RFWr(o_rf_wr), .IDEXE_DMRd(o_dm_rd), .IDEXE_DMWr(o_dm_wr),
        .IDEXE_WDSel(o_wd_sel), .IDEXE_ALUOp(o_alu_op),
        .IDEXE_ALUSrc1(o_alu_src1), .IDEXE_ALUSrc2(o_alu_src2),
        .IDEXE_PC(o_pc), .IDEXE_imm(o_imm), .IDEXE_rsdata(o_rs_data), .IDEXE_rtdata(o_rt_data),
        .IDEXE_valid(o_valid), .hazard_stall_o(hazard_stall_o)
    );

    assign dout = {o_valid, o_rs, o_rt, o_rd, o_rf_wr, o_dm_rd, o_dm_wr, o_wd_sel,
                   o_alu_op, o_alu_src1, o_alu_src2, o_pc, o_imm, o_rs_data, o_rt_data};

    function automatic id_t instr(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic dm_rd);
        id_t r;
        r          = '0;
        r.rs       = rs;
        r.rt       = rt;
        r.rd       = rd;
        r.rf_wr    = 1'b1;
        r.dm_rd    = dm_rd;
        r.dm_wr    = dm_rd ? 2'b00 : 2'($urandom_range(0, 3));
        r.wd_sel   = dm_rd ? 2'b01 : 2'b00;
        r.alu_op   = 5'($urandom_range(1, 31));
        r.alu_src1 = 1'($urandom_range(0, 1));
        r.alu_src2 = dm_rd;
        r.pc       = $urandom;
        r.imm      = $urandom;
        r.rs_data  = $urandom;
        r.rt_data  = $urandom;
        return r;
    endfunction

    task automatic checkOutput(input string tag);
        id_t e;
        total++;
        assert (exp_q.size() != 0) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=<empty scoreboard>", tag, dout);
            return;
        end
        e = exp_q.pop_front();
        assert (dout === e) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, dout, e);
        end
    endtask

    task automatic checkHazard(input string tag, input logic e);
        total++;
        assert (hazard_stall_o === e) else begin
            bad++;
            $error("[TB] FAIL %s: observed hazard_stall_o=%b expected=%b", tag, hazard_stall_o, e);
        end
    endtask

    // ctl = {stall, flush, use_rs, use_rt, is_branch}; called one time unit after a rising edge.
    task automatic applyStimulus(input string tag, input id_t d, input logic [4:0] ctl,
                                 input logic exp_hz, input int kind);
        din = d;
        {stall_i, flush_i, use_rs_i, use_rt_i, is_branch_i} = ctl;
        #1;
        checkHazard({tag, "_hz"}, exp_hz);
        if (kind == K_LOAD) begin
            last_exp = d;
            last_exp.valid = 1'b1;
        end else if (kind == K_BUB) begin
            last_exp = '0;
        end
        exp_q.push_back(last_exp);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        id_t lw8, add9, lw0, add00, lw31, usert, lw7, nouse, lw5, beq, other;
        lw8   = instr(5'd0, 5'd8, 5'd8, 1'b1);
        add9  = instr(5'd8, 5'd10, 5'd9, 1'b0);
        lw0   = instr(5'd1, 5'd0, 5'd0, 1'b1);
        add00 = instr(5'd0, 5'd0, 5'd9, 1'b0);
        lw31  = instr(5'd2, 5'd31, 5'd31, 1'b1);
        usert = instr(5'd4, 5'd31, 5'd12, 1'b0);
        lw7   = instr(5'd3, 5'd7, 5'd7, 1'b1);
        nouse = instr(5'd7, 5'd7, 5'd13, 1'b0);
        lw5   = instr(5'd6, 5'd5, 5'd5, 1'b1);
        beq   = instr(5'd5, 5'd0, 5'd0, 1'b0);
        beq.rf_wr = 1'b0;
        other = instr(5'd9, 5'd11, 5'd14, 1'b0);

        #2;
        exp_q.push_back('0);
        checkOutput("reset_values");
        checkHazard("reset_hz", 1'b0);
        #10 rstn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("lw8", lw8, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("add_bubble", add9, 5'b00100, 1'b1, K_BUB);
        applyStimulus("add_load", add9, 5'b00100, 1'b0, K_LOAD);
        applyStimulus("alu_no_hz", other, 5'b00110, 1'b0, K_LOAD);

        applyStimulus("lw0", lw0, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("add_r0", add00, 5'b00110, 1'b0, K_LOAD);

        applyStimulus("lw31", lw31, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("rt31_bubble", usert, 5'b00010, 1'b1, K_BUB);
        applyStimulus("rt31_load", usert, 5'b00010, 1'b0, K_LOAD);

        applyStimulus("lw7", lw7, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("no_use", nouse, 5'b00000, 1'b0, K_LOAD);

        applyStimulus("brA_lw5", lw5, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("brA_bub1", beq, 5'b00111, 1'b1, K_BUB);
`ifdef IDEXE_BRANCH_LU_EN
        applyStimulus("brA_bub2", beq, 5'b00111, 1'b1, K_BUB);
`endif
        applyStimulus("brA_load", beq, 5'b00111, 1'b0, K_LOAD);

        applyStimulus("brB_lw5", lw5, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("brB_bub1", beq, 5'b00111, 1'b1, K_BUB);
        for (int i = 0; i < 3; i++) begin
`ifdef IDEXE_BRANCH_LU_EN
            applyStimulus("brB_stall", beq, 5'b10111, 1'b1, K_HOLD);
`else
            applyStimulus("brB_stall", beq, 5'b10111, 1'b0, K_HOLD);
`endif
        end
        applyStimulus("brB_flush", beq, 5'b01111, 1'b0, K_BUB);
        applyStimulus("brB_load", beq, 5'b00111, 1'b0, K_LOAD);

        applyStimulus("st_lw8", lw8, 5'b00000, 1'b0, K_LOAD);
        applyStimulus("st_hold", add9, 5'b10100, 1'b1, K_HOLD);
        applyStimulus("st_flush", add9, 5'b01100, 1'b0, K_BUB);
        applyStimulus("st_load", add9, 5'b00100, 1'b0, K_LOAD);
        applyStimulus("flush_plain", other, 5'b01000, 1'b0, K_BUB);

        for (int i = 0; i < 4; i++) begin
            applyStimulus("rand_load", instr(5'($urandom), 5'($urandom), 5'($urandom), 1'b0),
                          5'b00000, 1'b0, K_LOAD);
        end

        applyStimulus("mh_lw8", lw8, 5'b00000, 1'b0, K_LOAD);
        din = add9;
        {stall_i, flush_i, use_rs_i, use_rt_i, is_branch_i} = 5'b00100;
        #1;
        checkHazard("mh_hz", 1'b1);
        #2 rstn = 1'b0;
        #1;
        last_exp = '0;
        exp_q.push_back('0);
        checkOutput("mh_async_reset");
        checkHazard("mh_reset_hz", 1'b0);
        @(posedge clk);
        #3 rstn = 1'b1;
        applyStimulus("mh_after", add9, 5'b00100, 1'b0, K_LOAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idexe_reg.md
IDEXE_REG -- requirements
Module: idexe_reg

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: stall_i  in  1  external freeze (memory wait); holds all state.
REQ-004 SHALL have ports: flush_i  in  1  kill the instruction in ID (taken branch/jump).
REQ-005 SHALL have ports: IFID_rs, IFID_rt  in  5 each  source registers of the ID instruction.
REQ-006 SHALL have ports: use_rs_i, use_rt_i  in  1 each  ID instruction actually reads rs/rt.
REQ-007 SHALL have ports: is_branch_i  in  1  ID instruction resolves its branch in ID.
REQ-008 SHALL have ports: rd_i  in  5 ; RFWr_i, DMRd_i, ALUSrc1_i, ALUSrc2_i  in  1 ; DMWr_i  in  2 ; WDSel_i  in  2 ; ALUOp_i  in  5  decoded controls.
REQ-009 SHALL have ports: PC_i, imm_i, rsdata_i, rtdata_i  in  32 each  ID datapath values.
REQ-010 SHALL have ports: IDEXE_rs, IDEXE_rt, IDEXE_rd, IDEXE_RFWr, IDEXE_DMRd, IDEXE_DMWr, IDEXE_WDSel, IDEXE_ALUOp, IDEXE_ALUSrc1, IDEXE_ALUSrc2, IDEXE_PC, IDEXE_imm, IDEXE_rsdata, IDEXE_rtdata  out  widths as inputs  registered EXE-stage fields.
REQ-011 SHALL have ports: IDEXE_valid  out  1  registered; 0 = bubble.
REQ-012 SHALL have ports: hazard_stall_o  out  1  combinational; freeze PC and IF/ID this cycle.

Function
REQ-013 Update priority each rising edge SHALL be: stall_i (hold all) > flush_i (bubble) > hazard (bubble) > normal load of ID fields.
REQ-014 Bubble SHALL set IDEXE_valid=0, RFWr=0, DMRd=0, DMWr=2'b00 (DMWr_NOP), rs=rt=rd=0, ALUOp=0, ALUSrc1=ALUSrc2=0, WDSel=0, all 32-bit fields=0.
REQ-015 Normal load SHALL copy every *_i field to its IDEXE_* register (IFID_rs/rt into IDEXE_rs/rt) and set IDEXE_valid=1; latency exactly one cycle.
REQ-016 Load-use term lu SHALL be IDEXE_valid & IDEXE_DMRd & (IDEXE_rd!=0) & ((use_rs_i & IFID_rs==IDEXE_rd) | (use_rt_i & IFID_rt==IDEXE_rd)).
REQ-017 FSM states SHALL be IDLE and BUB2; reset state IDLE.
REQ-018 In IDLE: hazard_stall_o = lu & ~flush_i; if lu & ~flush_i & ~stall_i, bubble inserted; next state BUB2 if is_branch_i else IDLE.
REQ-019 In BUB2: hazard_stall_o = ~flush_i; if ~stall_i, bubble inserted and next state IDLE.
REQ-020 stall_i=1 SHALL hold FSM state and all registers; hazard_stall_o still evaluated per REQ-018/019.
REQ-021 flush_i=1 with stall_i=0 SHALL insert a bubble, force state IDLE and drive hazard_stall_o=0, including from BUB2.
REQ-022 rd=0 SHALL never create a hazard; rd=31 SHALL be treated as an ordinary register here.

Reset
REQ-023 rstn=0 SHALL asynchronously clear all IDEXE_* outputs to bubble values (REQ-014), state to IDLE.
REQ-024 Deassertion SHALL take effect at the first rising clk with rstn=1; reset mid-hazard abandons the hazard.

Configuration
REQ-025 Macro IDEXE_BRANCH_LU_EN defined: BUB2 present, branch depending on a load receives two bubbles.
REQ-026 Macro IDEXE_BRANCH_LU_EN undefined: BUB2 absent, FSM stays IDLE, every load-use (branch or not) receives exactly one bubble.

Verification
REQ-027 Reset: rstn=0 mid-cycle -> all outputs 0, IDEXE_valid=0 immediately, no clk edge needed.
REQ-028 lw $8 then add $9,$8,$10 (use_rs_i=1) -> hazard_stall_o=1 one cycle, one bubble, then add loads with IDEXE_rs=8.
REQ-029 With IDEXE_BRANCH_LU_EN: lw $5 then beq $5,$0 (is_branch_i=1) -> hazard_stall_o=1 two consecutive cycles, two bubbles; undefined -> one.
REQ-030 lw $0 then add $9,$0,$0 -> hazard_stall_o=0, no bubble.
REQ-031 stall_i=1 for 3 cycles during BUB2 -> registers frozen, state BUB2 kept; flush_i=1 in BUB2 -> bubble, IDLE, hazard_stall_o=0.
